// File: rtl/adc_capture_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | adc_capture_scheduler                                                        |
// | Round-robin frame writer sharing one FIFO write port between four ADC chans. |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module adc_capture_scheduler #(
    parameter int FRAME_LEN  = 1024,
    parameter int NUM_ROUNDS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [3:0]  ch_mask,
    input  logic        sample_valid,
    input  logic [15:0] adc1,
    input  logic [13:0] adc2,
    input  logic [13:0] adc4,
    input  logic [13:0] adc8,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_din,
    output logic        busy,
    output logic        overflow,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_HDR  = 3'd2,
        S_DATA = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [15:0] c_last_idx = 16'(FRAME_LEN - 1);
    localparam logic [31:0] c_rounds   = 32'(NUM_ROUNDS);

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  ch_q, ch_d;
    logic [5:0]  seq_q, seq_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] round_q, round_d;
    logic        overflow_q, overflow_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] din_q, din_d;
    logic        busy_q, busy_d;

    logic [2:0]  w_next;
    logic [15:0] w_sample;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_set = 2'(i);
        end
    endfunction

    // Returns {wrapped, channel}: the nearest set bit above cur, else the lowest set bit.
    function automatic logic [2:0] next_set(input logic [3:0] m, input logic [1:0] cur);
        next_set = {1'b1, lowest_set(m)};
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_set = {1'b0, 2'(i)};
        end
    endfunction

    always_comb begin
        case (ch_q)
            2'd0:    w_sample = adc1;
            2'd1:    w_sample = {{2{adc2[13]}}, adc2};
            2'd2:    w_sample = {{2{adc4[13]}}, adc4};
            default: w_sample = {{2{adc8[13]}}, adc8};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        start_d    = start;
        mask_d     = mask_q;
        ch_d       = ch_q;
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        round_d    = round_q;
        overflow_d = overflow_q;
        wr_en_d    = 1'b0;
        din_d      = din_q;
        w_next     = next_set(mask_q, ch_q);

        case (state_q)
            S_IDLE: begin
                if (start && !start_q && (ch_mask != 4'd0)) begin
                    mask_d     = ch_mask;
                    overflow_d = 1'b0;
                    round_d    = 32'd0;
                    seq_d      = 6'd0;
                    cnt_d      = 16'd0;
                    ch_d       = lowest_set(ch_mask);
                    state_d    = S_ARM;
                end
            end
            S_ARM: begin
                if (stop)            state_d = S_IDLE;
                else if (fifo_empty) state_d = S_HDR;
            end
            S_HDR: begin
                if (!fifo_full) begin
                    wr_en_d = 1'b1;
                    din_d   = {8'hA5, ch_q, seq_q};
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (sample_valid) begin
                    if (fifo_full) begin
                        // Dropped sample aborts the frame; seq stays on the aborted number.
                        overflow_d = 1'b1;
                        cnt_d      = 16'd0;
                        state_d    = S_DONE;
                    end else begin
                        wr_en_d = 1'b1;
                        din_d   = w_sample;
                        if (cnt_q == c_last_idx) begin
                            cnt_d   = 16'd0;
                            seq_d   = seq_q + 6'd1;
                            state_d = S_NEXT;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
            end
            S_NEXT: begin
                ch_d    = w_next[1:0];
                round_d = round_q + {31'd0, w_next[2]};
                if (stop || ((c_rounds != 32'd0) && (round_d == c_rounds))) state_d = S_DONE;
                else                                                        state_d = S_HDR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            mask_q     <= 4'd0;
            ch_q       <= 2'd0;
            seq_q      <= 6'd0;
            cnt_q      <= 16'd0;
            round_q    <= 32'd0;
            overflow_q <= 1'b0;
            wr_en_q    <= 1'b0;
            din_q      <= 16'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            mask_q     <= mask_d;
            ch_q       <= ch_d;
            seq_q      <= seq_d;
            cnt_q      <= cnt_d;
            round_q    <= round_d;
            overflow_q <= overflow_d;
            wr_en_q    <= wr_en_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
        end
    end

    assign fifo_wr_en = wr_en_q;
    assign fifo_din   = din_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_adc_capture_scheduler                                                     |
// | Directed bench: three scheduler instances with different frame/round setups. |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module tb_adc_capture_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  ch_mask = 4'd0;
    logic        sample_valid = 1'b0;
    logic [15:0] adc1 = 16'd0;
    logic [13:0] adc2 = 14'd0, adc4 = 14'd0, adc8 = 14'd0;
    logic        fifo_full = 1'b0, fifo_empty = 1'b1;

    logic        wr_a, wr_b, wr_c;
    logic [15:0] din_a, din_b, din_c;
    logic        busy_a, busy_b, busy_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic [2:0]  st_a, st_b, st_c;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_rr [12] = '{16'hA540, 16'hFFFF, 16'hFFFF, 16'hA5C1, 16'h0123, 16'h0123,
                                 16'hA542, 16'hFFFF, 16'hFFFF, 16'hA5C3, 16'h0123, 16'h0123};
    logic [15:0] q_b [$];
    logic [15:0] q_c [$];

    always #5 clk = ~clk;

    adc_capture_scheduler #(.FRAME_LEN(4), .NUM_ROUNDS(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop), .ch_mask(ch_mask),
        .sample_valid(sample_valid), .adc1(adc1), .adc2(adc2), .adc4(adc4), .adc8(adc8),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_wr_en(wr_a), .fifo_din(din_a),
        .busy(busy_a), .overflow(ovf_a), .state(st_a));

    adc_capture_scheduler #(.FRAME_LEN(2), .NUM_ROUNDS(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop), .ch_mask(ch_mask),
        .sample_valid(sample_valid), .adc1(adc1), .adc2(adc2), .adc4(adc4), .adc8(adc8),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_wr_en(wr_b), .fifo_din(din_b),
        .busy(busy_b), .overflow(ovf_b), .state(st_b));

    adc_capture_scheduler #(.FRAME_LEN(2), .NUM_ROUNDS(0)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .stop(stop), .ch_mask(ch_mask),
        .sample_valid(sample_valid), .adc1(adc1), .adc2(adc2), .adc4(adc4), .adc8(adc8),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_wr_en(wr_c), .fifo_din(din_c),
        .busy(busy_c), .overflow(ovf_c), .state(st_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first, last;

        // Reset values
        repeat (3) step();
        check("rst_wr",    32'(wr_a), 0);
        check("rst_din",   32'(din_a), 0);
        check("rst_busy",  32'(busy_a), 0);
        check("rst_ovf",   32'(ovf_a), 0);
        check("rst_state", 32'(st_a), 0);
        check("rst_state_c", 32'(st_c), 0);
        rst = 1'b0;
        step();

        // Single channel, one round, FRAME_LEN=4
        ch_mask = 4'b0001; sample_valid = 1'b1; adc1 = 16'h0010;
        start_a = 1'b1;
        step();
        check("a_arm", 32'(st_a), 1);
        check("a_busy", 32'(busy_a), 1);
        step();
        check("a_hdr_state", 32'(st_a), 2);
        check("a_hdr_nowr", 32'(wr_a), 0);
        step();
        check("a_hdr_wr", 32'(wr_a), 1);
        check("a_hdr_word", 32'(din_a), 32'hA500);
        check("a_data_state", 32'(st_a), 3);
        for (int i = 0; i < 4; i++) begin
            adc1 = 16'(16'h0010 + i);
            step();
            check("a_data_wr", 32'(wr_a), 1);
            check("a_data", 32'(din_a), 32'h0010 + 32'(i));
        end
        check("a_next", 32'(st_a), 4);
        step();
        check("a_done", 32'(st_a), 5);
        check("a_done_nowr", 32'(wr_a), 0);
        check("a_done_busy", 32'(busy_a), 1);
        step();
        check("a_idle", 32'(st_a), 0);
        check("a_idle_busy", 32'(busy_a), 0);

        // Zero mask: start edge ignored
        start_a = 1'b0; step();
        ch_mask = 4'b0000; start_a = 1'b1; step();
        check("a_mask0_state", 32'(st_a), 0);
        check("a_mask0_busy", 32'(busy_a), 0);

        // Round-robin with skip, two rounds, FRAME_LEN=2
        ch_mask = 4'b1010; adc2 = 14'h3FFF; adc8 = 14'h0123; adc4 = 14'h2000;
        start_b = 1'b1;
        first = -1; last = -1;
        for (int c = 0; c < 80; c++) begin
            step();
            if (wr_b) begin
                q_b.push_back(din_b);
                if (first < 0) first = c;
                last = c;
            end
            if (!busy_b) break;
        end
        check("b_rr_done", 32'(busy_b), 0);
        check("b_rr_count", 32'(q_b.size()), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < q_b.size()) check("b_rr_word", 32'(q_b[i]), 32'(exp_rr[i]));
        end
        check("b_rr_span", 32'(last - first), 14);

        // Header stall under fifo_full, then overflow on the second frame
        start_b = 1'b0; ch_mask = 4'b0001; step();
        start_b = 1'b1; fifo_full = 1'b1; step();
        check("b_st_arm", 32'(st_b), 1);
        step();
        check("b_st_hdr", 32'(st_b), 2);
        for (int i = 0; i < 5; i++) begin
            step();
            check("b_stall_nowr", 32'(wr_b), 0);
            check("b_stall_state", 32'(st_b), 2);
        end
        fifo_full = 1'b0; step();
        check("b_st_hdr_wr", 32'(wr_b), 1);
        check("b_st_hdr_word", 32'(din_b), 32'hA500);
        adc1 = 16'h1234; step();
        check("b_st_d0", 32'(din_b), 32'h1234);
        adc1 = 16'h5678; step();
        check("b_st_d1", 32'(din_b), 32'h5678);
        check("b_st_next", 32'(st_b), 4);
        step();
        check("b_st_hdr2", 32'(st_b), 2);
        check("b_gap_nowr", 32'(wr_b), 0);
        step();
        check("b_hdr2_word", 32'(din_b), 32'hA501);
        adc1 = 16'hAAAA; step();
        check("b_f2_d0", 32'(din_b), 32'hAAAA);
        fifo_full = 1'b1; step();
        check("b_ovf_nowr", 32'(wr_b), 0);
        check("b_ovf_flag", 32'(ovf_b), 1);
        check("b_ovf_done", 32'(st_b), 5);
        fifo_full = 1'b0; step();
        check("b_ovf_idle", 32'(st_b), 0);
        check("b_ovf_nowr2", 32'(wr_b), 0);
        check("b_ovf_sticky", 32'(ovf_b), 1);
        start_b = 1'b0; step();
        start_b = 1'b1; step();
        check("b_rearm_ovf", 32'(ovf_b), 0);
        check("b_rearm_state", 32'(st_b), 1);
        stop = 1'b1; step();
        check("b_arm_stop", 32'(st_b), 0);
        check("b_arm_stop_nowr", 32'(wr_b), 0);
        stop = 1'b0;

        // Stop mid-frame with gapped sample_valid (FRAME_LEN=2, unlimited rounds)
        start_c = 1'b1; step(); step(); step();
        check("c_hdr_word", 32'(din_c), 32'hA500);
        sample_valid = 1'b0; stop = 1'b1; step();
        check("c_gap0", 32'(wr_c), 0);
        sample_valid = 1'b1; adc1 = 16'h0101; step();
        check("c_d0", 32'(din_c), 32'h0101);
        sample_valid = 1'b0; step();
        check("c_gap1", 32'(wr_c), 0);
        check("c_gap1_state", 32'(st_c), 3);
        sample_valid = 1'b1; adc1 = 16'h0202; step();
        check("c_d1", 32'(din_c), 32'h0202);
        check("c_d1_next", 32'(st_c), 4);
        step();
        check("c_stop_done", 32'(st_c), 5);
        check("c_stop_nowr", 32'(wr_c), 0);
        step();
        check("c_stop_idle", 32'(st_c), 0);
        stop = 1'b0;

        // Sequence wrap over 65 frames
        start_c = 1'b0; adc1 = 16'h0000; step();
        start_c = 1'b1;
        for (int c = 0; c < 400 && q_c.size() < 195; c++) begin
            step();
            if (wr_c) q_c.push_back(din_c);
        end
        check("c_wrap_count", 32'(q_c.size()), 195);
        if (q_c.size() == 195) begin
            check("c_seq1", 32'(q_c[3]), 32'hA501);
            check("c_seq63", 32'(q_c[189]), 32'hA53F);
            check("c_seq_wrap", 32'(q_c[192]), 32'hA500);
        end
        stop = 1'b1;
        for (int c = 0; c < 20 && busy_c; c++) step();
        check("c_wrap_stop", 32'(busy_c), 0);
        stop = 1'b0;

        // Asynchronous reset mid-DATA
        start_c = 1'b0; step();
        start_c = 1'b1; step(); step(); step();
        step();
        check("c_pre_rst_wr", 32'(wr_c), 1);
        check("c_pre_rst_state", 32'(st_c), 3);
        #2 rst = 1'b1;
        #1;
        check("c_rst_wr", 32'(wr_c), 0);
        check("c_rst_state", 32'(st_c), 0);
        check("c_rst_busy", 32'(busy_c), 0);
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_capture_scheduler.md
# adc_capture_scheduler

Frame-based capture scheduler in the ADC divided-clock domain. Shares the single write port of the ADC-to-Ethernet width-converter FIFO between four ADC channels (adc1, adc2, adc4, adc8). On a start event it writes one frame per enabled channel in round-robin order, each frame being one header word followed by FRAME_LEN samples. It sits between the ADC deserializer outputs and the FIFO write side, replacing the single-channel write controller.

## Interface
- FRAME_LEN, 1024: samples per frame, excluding the header; legal range 2..65535.
- NUM_ROUNDS, 0: number of complete round-robin passes before stopping; 0 means run until `stop`.
- clk  in  1  ADC divided clock (adc_clk).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level input; its rising edge arms a capture.
- stop  in  1  level input; requests a stop at the next frame boundary.
- ch_mask  in  4  per-channel enable; bit0=adc1, bit1=adc2, bit2=adc4, bit3=adc8. Sampled at arm.
- sample_valid  in  1  the ADC words are valid this cycle (en_synced & aligned).
- adc1  in  16  channel 0 sample.
- adc2, adc4, adc8  in  14 each  channels 1–3, two's complement.
- fifo_full  in  1  FIFO full, write-clock domain.
- fifo_empty  in  1  FIFO empty, write-clock domain.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_din  out  16  FIFO write data.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky; cleared only by rst or by the next arm.
- state  out  3  encoded state for the ILA: IDLE=0, ARM=1, HDR=2, DATA=3, NEXT=4, DONE=5.

## Operation
- IDLE:
  - A rising edge on `start` latches `ch_mask` and clears `overflow`, the round counter and the frame sequence.
  - If the latched mask is 0, the edge is ignored and the block stays in IDLE.
  - Otherwise: channel pointer = lowest set bit, then go to ARM.
- ARM: wait for `fifo_empty`=1, then go to HDR.
- HDR:
  - When `fifo_full`=0, write one header word {8'hA5, ch[1:0], seq[5:0]}, then go to DATA.
  - `seq` is a 6-bit frame sequence number that increments after every completed frame and wraps from 63 to 0.
  - If `fifo_full`=1, stall in HDR with no write.
- DATA:
  - Every cycle with `sample_valid`=1, write the selected channel's sample.
  - adc1 is written as-is; 14-bit channels are sign-extended to 16 bits.
  - After FRAME_LEN writes, go to NEXT.
  - Cycles with `sample_valid`=0 produce no write and no count.
- Overflow: if `fifo_full`=1 while `sample_valid`=1 in DATA, the sample is dropped, `overflow` is set and the frame is aborted. An aborted frame does not increment `seq`. Go to DONE.
- NEXT:
  - Advance the channel pointer to the next set bit of the latched mask, wrapping upward (round-robin).
  - Wrapping back to the lowest set bit completes a round.
  - Go to DONE if `stop`=1, or if NUM_ROUNDS≠0 and the completed-round count equals NUM_ROUNDS. Otherwise go to HDR.
- DONE: one cycle, then IDLE. `start` must go low and high again to re-arm.
- `stop` asserted in ARM: return to IDLE with no writes.
- `stop` in HDR or DATA takes effect only at NEXT; frames are never truncated by `stop`.

## Timing
- Reset values: fifo_wr_en=0, fifo_din=0, busy=0, overflow=0, state=0 (IDLE). Internal counters and the pointer reset to 0.
- All outputs are registered. A sample presented at cycle n with `sample_valid`=1 appears on fifo_din/fifo_wr_en at cycle n+1.
- `start` edge detection uses a registered copy of `start`. The edge at cycle n gives state=ARM at n+1.
- `fifo_full` and `fifo_empty` are used combinationally in the cycle they are sampled. No write occurs in a cycle where `fifo_full` was 1 at the preceding edge.
- DATA→NEXT occurs on the clock edge that performs the FRAME_LEN-th write. NEXT→HDR takes 1 cycle, so there is exactly one idle write cycle between frames.
- `overflow` rises on the same edge on which the sample is dropped.
- Asynchronous `rst` mid-frame forces IDLE immediately and deasserts fifo_wr_en the same instant. Release is handled by the upstream reset bridge.

## Test plan
- Single channel, no backpressure: mask=4'b0001, FRAME_LEN=4, NUM_ROUNDS=1, `sample_valid` always 1, adc1 ramps 0x0010.. -> writes A500, then 4 consecutive adc1 values; DONE; busy low 2 cycles after the last write.
- Round-robin with skip: mask=4'b1010, FRAME_LEN=2, NUM_ROUNDS=2 -> header channel order 1,3,1,3; headers A540? no — headers A540 = {A5,01,000000}, A5C1, A542, A5C3; 8 data words; adc2=0x3FFF is written as 0xFFFF.
- Stall: `fifo_full` held high for 5 cycles during HDR -> no writes during those cycles, then the header is written; data is unaffected.
- Overflow: `fifo_full` rises mid-DATA with `sample_valid`=1 -> that sample is dropped, overflow=1, state goes DONE then IDLE, no further writes. The next start edge clears overflow.
- Stop and gaps: `stop` asserted in the middle of frame 0, with `sample_valid` toggling every other cycle -> frame 0 completes with the full FRAME_LEN writes, then no further header is written.
- Reset and sequence wrap: rst asserted mid-DATA -> fifo_wr_en goes to 0 asynchronously and state=0. Run 65 frames -> `seq` wraps from 63 to 0.
